uart_tx_fifo: RTL

- Serial transmit stage directly downstream of the terminal buffer.
- Accepts 1-cycle byte strobes (o_byte/o_byte_v from the buffer) into a small FIFO, then serialises each byte as 8N1 UART on o_tx_serial.
- Returns o_tx_active/o_tx_done status to the buffer's i_tx_active/i_tx_done inputs.
- The FIFO absorbs bursts: escape sequences are emitted every 2 cycles without waiting for tx_done.

---
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; bytes arrive as 1-cycle strobes
// and are serialised LSB first, with frame active/done status returned upstream.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_v,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d, full_q, full_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic              push, pop;

  // A pop in the same cycle never makes room for a push while full.
  assign push = i_byte_v && (count_q < DEPTH_C);
  assign pop  = (state_q == IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_byte;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = done_q;

    if (i_byte_v && !push) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_W + 1)'(1);

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (pop) begin
          shift_d   = mem[rd_ptr_q];
          clk_cnt_d = '0;
          serial_d  = 1'b0;
          active_d  = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            // The line always carries shift_q[0]; shift to expose the next bit.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          active_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;
  assign o_full      = full_q;
  assign o_overflow  = ovf_q;

endmodule
